// File: rtl/axi4lite_ram_responder.sv
// AXI4-Lite slave RAM model: byte-strobed word array, fixed read latency,
// SLVERR for addresses outside the window. Memory contents survive reset.
module axi4lite_ram_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    // state  | meaning
    // R_IDLE | ready for a read address
    // R_WAIT | latency countdown running
    // R_RESP | read data presented, waiting for rready
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STRB_W    = DATA_WIDTH / 8;
    localparam int OFFS_BITS = $clog2(STRB_W);
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_W);
    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> OFFS_BITS);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // ---------------- write path ----------------
    logic                  aw_held_q, w_held_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_hs, w_hs, commit, wr_ok;
    logic [IDX_W-1:0]      wr_idx;

    assign s_awready = !aw_held_q;
    assign s_wready  = !w_held_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;

    assign aw_hs  = s_awvalid && !aw_held_q;
    assign w_hs   = s_wvalid && !w_held_q;
    assign commit = aw_held_q && w_held_q && (!bvalid_q || s_bready);
    assign wr_ok  = in_range(awaddr_q);
    assign wr_idx = word_idx(awaddr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs)       aw_held_q <= 1'b1;
            else if (commit) aw_held_q <= 1'b0;
            if (w_hs)        w_held_q  <= 1'b1;
            else if (commit) w_held_q  <= 1'b0;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Payload holding registers need no reset; the held flags qualify them.
    always_ff @(posedge clk) begin
        if (aw_hs) awaddr_q <= s_awaddr;
        if (w_hs) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) mem_q[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    logic [1:0]            r_state_q, r_state_d;
    logic [3:0]            r_cnt_q, r_cnt_d;
    logic [ADDR_WIDTH-1:0] araddr_q, rd_addr;
    logic                  rvalid_q, ar_hs, enter_resp, rd_ok;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      rd_idx;

    assign s_arready = (r_state_q == R_IDLE);
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

    assign ar_hs = s_arvalid && (r_state_q == R_IDLE);
    // With a latency of one, the response is loaded on the handshake edge itself.
    assign rd_addr = (r_state_q == R_IDLE) ? s_araddr : araddr_q;
    assign rd_ok   = in_range(rd_addr);
    assign rd_idx  = word_idx(rd_addr);

    always_comb begin
        r_state_d  = r_state_q;
        r_cnt_d    = r_cnt_q;
        enter_resp = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_cnt_d = LAT_M1;
                    if (LAT_M1 == 4'd0) begin
                        r_state_d  = R_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - 4'd1;
                if (r_cnt_q == 4'd1) begin
                    r_state_d  = R_RESP;
                    enter_resp = 1'b1;
                end
            end
            R_RESP: begin
                if (s_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= 4'd0;
            araddr_q  <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            if (ar_hs) araddr_q <= s_araddr;
            if (enter_resp) begin
                rvalid_q <= 1'b1;
                rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                rdata_q  <= rd_ok ? mem_q[rd_idx] : '0;
            end else if ((r_state_q == R_RESP) && s_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axi4lite_ram_responder.md
Name: axi4lite_ram_responder

Overview:
- AXI4-Lite slave backing memory that services the cache's RAM-side traffic: write-backs of dirty lines (AW/W/B) and line refills (AR/R).
- Sits behind the cache controller's AXI4-Lite master.
- Word-addressed internal array with byte strobes, configurable read latency and SLVERR on out-of-range addresses.
- Serves as the system-level memory model for cache verification.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width (multiple of 8)
MEM_DEPTH, 256, number of DATA_WIDTH words in the array
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 2, cycles from AR handshake to RVALID assertion (1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
s_awaddr  input  ADDR_WIDTH  write address
s_awvalid  input  1  write address valid
s_awready  output  1  write address ready
s_wdata  input  DATA_WIDTH  write data
s_wstrb  input  DATA_WIDTH/8  byte strobes
s_wvalid  input  1  write data valid
s_wready  output  1  write data ready
s_bresp  output  2  write response
s_bvalid  output  1  write response valid
s_bready  input  1  write response ready
s_araddr  input  ADDR_WIDTH  read address
s_arvalid  input  1  read address valid
s_arready  output  1  read address ready
s_rdata  output  DATA_WIDTH  read data
s_rresp  output  2  read response
s_rvalid  output  1  read data valid
s_rready  input  1  read data ready

Behaviour:
- Clock and reset: clk, rst_n; asynchronous active-low reset.
- Reset values: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=2'b00, s_rresp=2'b00, s_rdata=0. Memory array is not reset.
- Address decode:
  - word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*DATA_WIDTH/8.
  - Out of range gives resp 2'b10 (SLVERR); otherwise 2'b00 (OKAY).
- Write path:
  - AW and W are accepted independently, in either order or the same cycle.
  - Each has a one-entry holding register. s_awready = !aw_held; s_wready = !w_held. A handshake sets the held flag and captures the payload.
  - Commit fires when aw_held && w_held && (!s_bvalid || s_bready).
  - On commit: for each strobe bit set, write that byte of the indexed word (in range only); clear both held flags; s_bvalid=1 and s_bresp set on the next edge.
  - s_wstrb=0 is a legal no-op write and returns OKAY.
  - s_bvalid and s_bresp stay stable until s_bready.
  - Back-to-back writes sustain one write per 2 cycles minimum (hold, then commit).
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: s_arready=1. On arvalid&&arready, latch address and load cnt=READ_LATENCY-1. Go to R_RESP if cnt==0, else R_WAIT.
  - R_WAIT: s_arready=0; cnt decrements each cycle. At cnt==1, go to R_RESP.
  - R_RESP entry edge: s_rdata = array word (or 0 if out of range), s_rresp set, s_rvalid=1. Values held stable while !s_rready.
  - R_RESP with s_rready: s_rvalid=0, return to R_IDLE. The next AR is accepted no earlier than the following cycle.
- Read/write interaction:
  - Read data is sampled at the R_RESP entry edge. A write committing on that same edge is not visible to the read.
  - A write committing on any earlier edge is visible.
  - Read and write channels are fully independent; no ordering between them.
- Reset mid-transaction: all held flags, the counter and the FSM return to reset state. Outstanding B/R responses are dropped; memory keeps its contents.
- No combinational path from any valid input to any ready output. Readies depend only on registered state.

Test Plan:
- Write then read, same cycle AW+W: AW=0x10, W=0xDEADBEEF, wstrb=4'hF, bready=1 -> BVALID 2 cycles after handshake, bresp=00. AR=0x10 -> RVALID exactly READ_LATENCY=2 cycles after AR handshake, rdata=0xDEADBEEF, rresp=00.
- W before AW, partial strobe: W=0x11223344, wstrb=4'b0101 at t, AW=0x10 at t+3 (word holds 0xDEADBEEF) -> no commit before t+3. Read-back gives 0xDE22BE44.
- Backpressure: bready=0 for 5 cycles after a write -> bvalid held, awready/wready stay 0 for the second write until B is taken. rready=0 for 4 cycles -> rdata/rvalid stable, arready=0 throughout.
- Out of range: AW=BASE_ADDR+0x400 (depth 256) -> bresp=10, no array change (verify word 0xFF unchanged). AR=0x400 -> rresp=10, rdata=0.
- Read/write collision: AR=0x20 (contents 0xA5A5A5A5) with write of 0x5A5A5A5A to 0x20 committing on the R_RESP entry edge -> rdata=0xA5A5A5A5. Subsequent read returns 0x5A5A5A5A.
- Reset mid-read: rst_n low during R_WAIT -> rvalid=0 and arready=1 immediately (asynchronous). After release, a fresh read returns previously written data.
